// File: rtl/soc_run_ctrl.sv
// -----------------------------------------------------------------------------
// soc_run_ctrl
//
// Run controller for the single-cycle RV32I SoC. Holds the core in reset while
// a host loader streams a program image into memory, releases the core, and
// ends the run on a store to the TOHOST word (halt) or when the cycle budget
// runs out (timeout). Also owns the memory write-port mux between the loader
// and the core data port.
//
// Optional feature macro: RUN_CTRL_WDT_KICK_EN
//   When defined, a core store to KICK_ADDR during RUN restarts an internal
//   watchdog and is kept out of memory; the timeout then measures cycles since
//   the last kick (or run start) instead of total RUN cycles.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_addr/
//   ld_data/ld_last                 loader beat handshake (word writes)
//   start                           run the existing image without loading
//   core_rst                        registered reset to the core, low in RUN
//   cd_we/cd_wstrb/cd_addr/cd_wdata core data-port write request
//   m_we/m_wstrb/m_addr/m_wdata     memory write port
//   busy                            LOAD or RUN
//   done/timeout                    sticky end-of-run status
//   exit_code                       data of the halting store
//   cycle_count                     RUN cycles of the last or current run
// -----------------------------------------------------------------------------
module soc_run_ctrl #(
    parameter logic [31:0] TOHOST_ADDR = 32'h1000_0004,
    parameter logic [31:0] MAX_CYCLES  = 32'd1_000_000,
    parameter logic [31:0] KICK_ADDR   = 32'h1000_0008
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    input  logic        start,

    output logic        core_rst,

    input  logic        cd_we,
    input  logic [3:0]  cd_wstrb,
    input  logic [31:0] cd_addr,
    input  logic [31:0] cd_wdata,

    output logic        m_we,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,

    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] exit_code,
    output logic [31:0] cycle_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_TOUT = 3'd4;

    // Budget is checked one cycle early so the run ends after exactly MAX_CYCLES.
    localparam logic [31:0] LAST_CYCLE = MAX_CYCLES - 32'd1;

    logic [2:0]  state_q, state_d;
    logic        core_rst_q, core_rst_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic [31:0] cycle_count_q, cycle_count_d;

    logic        in_run;
    logic        idle_like;
    logic        beat;
    logic        halt_hit;
    logic        kick_hit;
    logic        budget_hit;
    logic        tout_hit;
    logic        enter_run;
    logic        leave_end;
    logic [31:0] budget_cnt;

    // Low address bits of loader beats are ignored (word writes only).
    logic        unused_ld_addr;
    assign unused_ld_addr = ^ld_addr[1:0];

    // -------------------------------------------------------------------------
    // Decodes
    // -------------------------------------------------------------------------
    always_comb begin
        in_run    = (state_q == ST_RUN);
        idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_TOUT);
        ld_ready  = !in_run;
        beat      = ld_valid && ld_ready;
        halt_hit  = in_run && cd_we && (cd_addr[31:2] == TOHOST_ADDR[31:2]);
    end

`ifdef RUN_CTRL_WDT_KICK_EN
    logic [31:0] wdog_q, wdog_d;

    always_comb begin
        kick_hit   = in_run && cd_we && (cd_addr[31:2] == KICK_ADDR[31:2]);
        budget_cnt = wdog_q;
    end

    always_comb begin
        wdog_d = wdog_q;
        if (enter_run) begin
            wdog_d = 32'd0;
        end else if (in_run) begin
            wdog_d = kick_hit ? 32'd0 : wdog_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= 32'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // Without the watchdog, KICK_ADDR is an ordinary address.
    logic unused_kick_addr;
    assign unused_kick_addr = ^KICK_ADDR;

    always_comb begin
        kick_hit   = 1'b0;
        budget_cnt = cycle_count_q;
    end
`endif

    always_comb begin
        budget_hit = in_run && (budget_cnt == LAST_CYCLE);
        // Halt takes priority over an expiring budget in the same cycle.
        tout_hit   = budget_hit && !halt_hit;
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TOUT: begin
                // A loader beat wins over start in the same cycle.
                if (beat) begin
                    state_d = ld_last ? ST_RUN : ST_LOAD;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (beat && ld_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_d = ST_DONE;
                end else if (tout_hit) begin
                    state_d = ST_TOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        enter_run = (state_d == ST_RUN) && !in_run;
        leave_end = ((state_q == ST_DONE) || (state_q == ST_TOUT)) && (state_d != state_q);
    end

    // -------------------------------------------------------------------------
    // Status / counters next-state
    // -------------------------------------------------------------------------
    always_comb begin
        core_rst_d = (state_d != ST_RUN);

        done_d = done_q;
        if (leave_end) begin
            done_d = 1'b0;
        end
        if (halt_hit) begin
            done_d = 1'b1;
        end

        timeout_d = timeout_q;
        if (leave_end) begin
            timeout_d = 1'b0;
        end
        if (tout_hit) begin
            timeout_d = 1'b1;
        end

        exit_code_d = halt_hit ? cd_wdata : exit_code_q;

        cycle_count_d = cycle_count_q;
        if (enter_run) begin
            cycle_count_d = 32'd0;
        end else if (in_run) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            core_rst_q    <= 1'b1;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            exit_code_q   <= 32'd0;
            cycle_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            core_rst_q    <= core_rst_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            exit_code_q   <= exit_code_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Memory write-port mux
    // -------------------------------------------------------------------------
    always_comb begin
        m_we    = 1'b0;
        m_wstrb = 4'hF;
        m_addr  = {ld_addr[31:2], 2'b00};
        m_wdata = ld_data;
        if (in_run) begin
            // Control-word stores (halt, kick) never reach memory.
            m_we    = cd_we && !halt_hit && !kick_hit;
            m_wstrb = cd_wstrb;
            m_addr  = cd_addr;
            m_wdata = cd_wdata;
        end else begin
            m_we = beat;
        end
        if (rst) begin
            m_we = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        core_rst    = core_rst_q;
        busy        = (state_q == ST_LOAD) || in_run;
        done        = done_q;
        timeout     = timeout_q;
        exit_code   = exit_code_q;
        cycle_count = cycle_count_q;
    end

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Bench for soc_run_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a flag-based behavioural model.
module tb_soc_run_ctrl;

    localparam logic [31:0] TOHOST = 32'h1000_0004;
    localparam logic [31:0] KICK   = 32'h1000_0008;
    localparam int unsigned MAXC   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready, ld_last, start;
    logic [31:0] ld_addr, ld_data;
    logic        core_rst;
    logic        cd_we;
    logic [3:0]  cd_wstrb;
    logic [31:0] cd_addr, cd_wdata;
    logic        m_we;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        busy, done, timeout;
    logic [31:0] exit_code, cycle_count;

    always #5 clk = ~clk;

    soc_run_ctrl #(
        .TOHOST_ADDR(TOHOST),
        .MAX_CYCLES (32'd16),
        .KICK_ADDR  (KICK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .start      (start),
        .core_rst   (core_rst),
        .cd_we      (cd_we),
        .cd_wstrb   (cd_wstrb),
        .cd_addr    (cd_addr),
        .cd_wdata   (cd_wdata),
        .m_we       (m_we),
        .m_wstrb    (m_wstrb),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .exit_code  (exit_code),
        .cycle_count(cycle_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model: a run is either in progress, being loaded, or neither (idle-like);
    // done/tout remember how the last run ended.
    bit          md_run, md_load, md_done, md_tout;
    logic [31:0] md_exit, md_cnt, md_since;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    function automatic bit is_halt();
        return md_run && cd_we && same_word(cd_addr, TOHOST);
    endfunction

    function automatic bit is_kick();
`ifdef RUN_CTRL_WDT_KICK_EN
        return md_run && cd_we && same_word(cd_addr, KICK);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        md_run = 0; md_load = 0; md_done = 0; md_tout = 0;
        md_exit = 0; md_cnt = 0; md_since = 0;
    endtask

    task automatic model_enter_run();
        md_run = 1; md_load = 0; md_done = 0; md_tout = 0;
        md_cnt = 0; md_since = 0;
    endtask

    task automatic model_step();
        bit          halt;
        bit          kick;
        logic [31:0] elapsed;
        halt = is_halt();
        kick = is_kick();
        if (rst) begin
            model_reset();
        end else if (md_run) begin
`ifdef RUN_CTRL_WDT_KICK_EN
            elapsed = md_since + 1;
`else
            elapsed = md_cnt + 1;
`endif
            md_cnt   = md_cnt + 1;
            md_since = kick ? 32'd0 : md_since + 1;
            if (halt) begin
                md_exit = cd_wdata;
                md_done = 1;
                md_run  = 0;
            end else if (elapsed == MAXC) begin
                md_tout = 1;
                md_run  = 0;
            end
        end else if (ld_valid) begin
            if (ld_last) begin
                model_enter_run();
            end else if (!md_load) begin
                md_load = 1; md_done = 0; md_tout = 0;
            end
        end else if (start && !md_load) begin
            model_enter_run();
        end
    endtask

    task automatic check_outputs();
        bit exp_we;
        if (rst) begin
            exp_we = 0;
        end else if (md_run) begin
            exp_we = cd_we && !is_halt() && !is_kick();
        end else begin
            exp_we = ld_valid;
        end
        check("ld_ready", ld_ready, !md_run);
        check("m_we", m_we, exp_we);
        check("busy", busy, md_run || md_load);
        check("core_rst", core_rst, !md_run);
        check("done", done, md_done);
        check("timeout", timeout, md_tout);
        check("exit_code", exit_code, md_exit);
        check("cycle_count", cycle_count, md_cnt);
        if (exp_we && md_run) begin
            check("m_addr_core", m_addr, cd_addr);
            check("m_wdata_core", m_wdata, cd_wdata);
            check("m_wstrb_core", m_wstrb, cd_wstrb);
        end else if (exp_we) begin
            check("m_addr_ld", m_addr, ld_addr & 32'hFFFF_FFFC);
            check("m_wdata_ld", m_wdata, ld_data);
            check("m_wstrb_ld", m_wstrb, 4'hF);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; ld_valid = 0; ld_last = 0; start = 0; ld_addr = 0; ld_data = 0;
        cd_we = 0; cd_wstrb = 0; cd_addr = 0; cd_wdata = 0;
    endtask

    task automatic load_beat(input logic [31:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1; ld_addr = a; ld_data = d; ld_last = last;
        tick();
    endtask

    task automatic core_store(input logic [31:0] a, input logic [31:0] d);
        cd_we = 1; cd_addr = a; cd_wdata = d; cd_wstrb = 4'hF;
        tick();
        cd_we = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        model_reset();
        #1;
        tick();
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_cycle_count", cycle_count, 32'd0);
        rst = 0;
        tick();

        // Program load, ld_valid held across three beats.
        load_beat(32'h0, 32'h0050_0093, 1'b0);
        load_beat(32'h4, 32'h0000_0013, 1'b0);
        load_beat(32'h8, 32'h0000_006F, 1'b1);
        idle_inputs();
        check("load_core_rst", core_rst, 1'b0);
        check("load_busy", busy, 1'b1);

        // Halt store on the 5th RUN cycle.
        repeat (4) tick();
        core_store(TOHOST, 32'h2A);
        check("halt_done", done, 1'b1);
        check("halt_exit", exit_code, 32'h2A);
        check("halt_cycles", cycle_count, 32'd5);
        check("halt_core_rst", core_rst, 1'b1);

        // Full budget with no stores ends in TOUT.
        pulse_start();
        check("rerun_done_clr", done, 1'b0);
        check("rerun_cnt_clr", cycle_count, 32'd0);
        repeat (15) tick();
        check("tout_not_yet", timeout, 1'b0);
        tick();
        check("tout_flag", timeout, 1'b1);
        check("tout_cycles", cycle_count, MAXC);

        // Halt on the last budget cycle: halt wins.
        pulse_start();
        repeat (15) tick();
        core_store(TOHOST, 32'h55);
        check("edge_halt_done", done, 1'b1);
        check("edge_halt_tout", timeout, 1'b0);
        check("edge_halt_cycles", cycle_count, MAXC);

        // Rerun, then reset after 7 RUN cycles with a live store on the port.
        pulse_start();
        check("rerun2_core_rst", core_rst, 1'b0);
        repeat (7) tick();
        rst = 1; cd_we = 1; cd_addr = 32'h200; cd_wdata = 32'h1234; cd_wstrb = 4'h3;
        tick();
        idle_inputs();
        check("rstrun_ld_ready", ld_ready, 1'b1);
        check("rstrun_cnt", cycle_count, 32'd0);
        check("rstrun_core_rst", core_rst, 1'b1);

        // Beat and start together in IDLE: LOAD, not RUN.
        ld_valid = 1; start = 1; ld_addr = 32'h10; ld_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        check("beat_wins_core_rst", core_rst, 1'b1);
        check("beat_wins_busy", busy, 1'b1);
        pulse_start();
        check("load_ignores_start", core_rst, 1'b1);
        load_beat(32'h14, 32'h0, 1'b1);
        idle_inputs();
        repeat (3) tick();

`ifdef RUN_CTRL_WDT_KICK_EN
        // Kicks every 10 cycles keep the run alive past the budget.
        rst = 1;
        tick();
        rst = 0;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 9) begin
                core_store(KICK, i);
            end else begin
                tick();
            end
        end
        check("kick_no_tout", timeout, 1'b0);
        check("kick_cycles", cycle_count, 32'd50);
        repeat (15) tick();
        check("kick_tout_not_yet", timeout, 1'b0);
        tick();
        check("kick_tout", timeout, 1'b1);
`endif

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            int unsigned sel;
            rst      = ($urandom % 200) == 0;
            ld_valid = ($urandom % 3) == 0;
            ld_last  = ($urandom % 6) == 0;
            start    = ($urandom % 8) == 0;
            ld_addr  = $urandom;
            ld_data  = $urandom;
            cd_we    = ($urandom % 3) == 0;
            cd_wstrb = 4'($urandom);
            cd_wdata = $urandom;
            sel      = $urandom % 10;
            if (sel == 0) begin
                cd_addr = TOHOST | 32'($urandom % 4);
            end else if (sel == 1) begin
                cd_addr = KICK | 32'($urandom % 4);
            end else begin
                cd_addr = $urandom;
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
